// File: rtl/retire_trace_buffer.sv
// Retirement trace buffer: FWFT circular FIFO of retired instructions plus halt/idle-timeout bookkeeping.
// Define TRACE_WRAP_EN to overwrite the oldest entry when full (default: drop the newest).
module retire_trace_buffer #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ret_valid,
  input  logic [XLEN-1:0]          ret_pc,
  input  logic [31:0]              ret_ir,
  input  logic [4:0]               ret_rd,
  input  logic                     ret_we,
  input  logic [XLEN-1:0]          ret_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_ir,
  output logic [4:0]               out_rd,
  output logic                     out_we,
  output logic [XLEN-1:0]          out_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic [31:0]              retired_cnt,
  output logic [31:0]              cycle_cnt,
  output logic                     halted,
  output logic                     timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ir;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] wdata;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_rptr, r_wptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow, r_halted, r_timeout;
  logic [15:0]     r_drop;
  logic [31:0]     r_retired, r_cycle;
  logic [IW-1:0]   r_idle;

  logic            w_pop, w_acc, w_full, w_push, w_drop, w_wr, w_ovwr;
  logic            w_halt_ins, w_tmo;
  logic [IW-1:0]   w_idle_nxt;
  entry_t          w_new, w_head;

  assign w_pop  = (r_count != '0) && out_ready;
  assign w_acc  = ret_valid && !r_halted;
  assign w_full = (r_count == CW'(DEPTH));
  // A pop in the same cycle frees a slot, so push-at-full with pop is a normal push.
  assign w_push = w_acc && (!w_full || w_pop);
  assign w_drop = w_acc && w_full && !w_pop;

`ifdef TRACE_WRAP_EN
  assign w_ovwr = w_drop;
`else
  assign w_ovwr = 1'b0;
`endif
  assign w_wr = w_push || w_ovwr;

  assign w_halt_ins = w_acc && ((ret_ir == 32'h0000_0073) || (ret_ir == 32'h0010_0073));
  assign w_idle_nxt = r_idle + 1'b1;
  // A retirement on the would-be timeout edge clears the idle count, so timeout never fires with it.
  assign w_tmo      = !ret_valid && !r_halted && (w_idle_nxt == IW'(TIMEOUT));

  assign w_new = '{pc: ret_pc, ir: ret_ir, rd: ret_rd, we: ret_we, wdata: ret_wdata};

  always_ff @(posedge clk) begin
    if (rst && w_wr) r_mem[r_wptr] <= w_new;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
      r_retired  <= '0;
      r_cycle    <= '0;
      r_idle     <= '0;
      r_halted   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop || w_ovwr) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;

      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
      end
      if (w_acc) r_retired <= r_retired + 1'b1;
      if (!r_halted) r_cycle <= r_cycle + 1'b1;

      if (ret_valid) r_idle <= '0;
      else if (!r_halted) r_idle <= w_idle_nxt;

      if (w_halt_ins || w_tmo) r_halted <= 1'b1;
      if (w_tmo) r_timeout <= 1'b1;
    end
  end

  assign w_head      = r_mem[r_rptr];
  assign out_valid   = (r_count != '0);
  assign out_pc      = w_head.pc;
  assign out_ir      = w_head.ir;
  assign out_rd      = w_head.rd;
  assign out_we      = w_head.we;
  assign out_wdata   = w_head.wdata;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop;
  assign retired_cnt = r_retired;
  assign cycle_cnt   = r_cycle;
  assign halted      = r_halted;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer: vector table, directed corner cases, randomized run vs queue model.
module tb_retire_trace_buffer;
  localparam int XLEN = 32, DEPTH = 16, TIMEOUT = 8;

  logic clk = 1'b0, rst = 1'b0;
  logic ret_valid = 1'b0, ret_we = 1'b0, out_ready = 1'b0;
  logic [31:0] ret_pc = '0, ret_ir = '0, ret_wdata = '0;
  logic [4:0]  ret_rd = '0;
  logic out_valid, out_we, overflow, halted, timeout;
  logic [31:0] out_pc, out_ir, out_wdata, retired_cnt, cycle_cnt;
  logic [4:0]  out_rd;
  logic [4:0]  count;
  logic [15:0] drop_cnt;

  retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_ir(ret_ir),
    .ret_rd(ret_rd), .ret_we(ret_we), .ret_wdata(ret_wdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir), .out_rd(out_rd),
    .out_we(out_we), .out_wdata(out_wdata), .count(count), .overflow(overflow),
    .drop_cnt(drop_cnt), .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt),
    .halted(halted), .timeout(timeout));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc, ir; logic [4:0] rd; logic we; logic [31:0] wd; } ent_t;
  ent_t mq[$];
  logic [31:0] m_ret, m_cyc;
  int m_drop, m_idle;
  bit m_ovf, m_halt, m_tmo;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input ent_t e, input bit rdy);
    bit pop, acc, full, nh, nt;
    if (!r) begin
      mq.delete();
      m_ret = 0; m_cyc = 0; m_drop = 0; m_idle = 0;
      m_ovf = 0; m_halt = 0; m_tmo = 0;
    end else begin
      pop  = (mq.size() > 0) && rdy;
      acc  = v && !m_halt;
      full = (mq.size() == DEPTH);
      nh = m_halt; nt = m_tmo;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        m_ret++;
        if (full && !pop) begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
`ifdef TRACE_WRAP_EN
          void'(mq.pop_front());
          mq.push_back(e);
`endif
        end else mq.push_back(e);
        if (e.ir == 32'h73 || e.ir == 32'h0010_0073) nh = 1;
      end
      if (v) m_idle = 0;
      else if (!m_halt) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin nh = 1; nt = 1; end
      end
      if (!m_halt) m_cyc++;
      m_halt = nh; m_tmo = nt;
    end
  endtask

  task automatic compare_all();
    chk("count", count, mq.size());
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_ir", out_ir, mq[0].ir);
      chk("out_rd", out_rd, mq[0].rd);
      chk("out_we", out_we, mq[0].we);
      chk("out_wdata", out_wdata, mq[0].wd);
    end
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("retired_cnt", retired_cnt, m_ret);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("halted", halted, m_halt);
    chk("timeout", timeout, m_tmo);
  endtask

  // Drive one cycle of inputs, advance the model, and compare just after the edge.
  task automatic step(input bit r, input bit v, input logic [31:0] pc, input logic [31:0] ir,
                      input bit rdy);
    ent_t e;
    e.pc = pc; e.ir = ir; e.rd = pc[6:2]; e.we = pc[2]; e.wd = ~pc ^ ir;
    rst = r; ret_valid = v; ret_pc = e.pc; ret_ir = e.ir; ret_rd = e.rd;
    ret_we = e.we; ret_wdata = e.wd; out_ready = rdy;
    model(r, v, e, rdy);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 32'h13, 0);
  endtask

  typedef struct { bit r, v; logic [31:0] pc; bit rdy; int ecount; bit evalid; logic [31:0] epc; } vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{0, 0, 32'h0, 0, 0, 0, 32'h0};
    tbl[1] = '{1, 1, 32'h0, 0, 1, 1, 32'h0};
    tbl[2] = '{1, 1, 32'h4, 0, 2, 1, 32'h0};
    tbl[3] = '{1, 1, 32'h8, 0, 3, 1, 32'h0};
    tbl[4] = '{1, 0, 32'h0, 1, 2, 1, 32'h4};
    tbl[5] = '{1, 0, 32'h0, 1, 1, 1, 32'h8};
    tbl[6] = '{1, 0, 32'h0, 1, 0, 0, 32'h0};

    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].pc, 32'h13, tbl[i].rdy);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].ecount);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].evalid);
      if (tbl[i].evalid) chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
    end

    // Overflow at full with no consumer.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 32'h1000 + 4 * i, 32'h13, 0);
    chk("ovf_count", count, 16);
    chk("ovf_drop", drop_cnt, 4);
    chk("ovf_flag", overflow, 1);
`ifdef TRACE_WRAP_EN
    chk("ovf_head", out_pc, 32'h1010);
`else
    chk("ovf_head", out_pc, 32'h1000);
`endif

    // Full FIFO with simultaneous push and pop.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 1, 32'h2000 + 4 * i, 32'h13, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 32'h3000 + 4 * i, 32'h13, 1);
    chk("fullpp_count", count, 16);
    chk("fullpp_drop", drop_cnt, 0);
    chk("fullpp_head", out_pc, 32'h2020);

    // ECALL halts; later retirements ignored; cycle counter frozen.
    step(0, 0, 0, 0, 0);
    step(1, 1, 32'h100, 32'h0000_0073, 0);
    chk("ecall_halt", halted, 1);
    step(1, 1, 32'h104, 32'h13, 0);
    idle(2);
    chk("ecall_ret", retired_cnt, 1);
    chk("ecall_cyc", cycle_cnt, 1);
    chk("ecall_cnt", count, 1);
    chk("ecall_tmo", timeout, 0);
    step(1, 0, 0, 32'h13, 1);
    chk("ecall_drain", count, 0);

    // Idle timeout, and restart of the idle count.
    step(0, 0, 0, 0, 0);
    idle(7);
    chk("tmo7_halt", halted, 0);
    idle(1);
    chk("tmo8_halt", halted, 1);
    chk("tmo8_tmo", timeout, 1);
    step(0, 0, 0, 0, 0);
    idle(6);
    step(1, 1, 32'h200, 32'h13, 0);
    idle(7);
    chk("restart_halt", halted, 0);
    idle(1);
    chk("restart_tmo", timeout, 1);

    // EBREAK on the timeout edge: halts without timeout.
    step(0, 0, 0, 0, 0);
    idle(7);
    step(1, 1, 32'h300, 32'h0010_0073, 0);
    chk("race_halt", halted, 1);
    chk("race_tmo", timeout, 0);

    // Reset mid-operation.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 32'h400 + 4 * i, 32'h13, 0);
    step(0, 1, 32'h500, 32'h13, 1);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ret", retired_cnt, 0);
    chk("rst_cyc", cycle_cnt, 0);
    chk("rst_halt", halted, 0);

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      bit r, v, rdy;
      logic [31:0] ir;
      r   = ($urandom_range(0, 299) != 0);
      v   = ((i / 400) % 3 == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rdy = ((i / 250) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ir  = $urandom;
      if ($urandom_range(0, 149) == 0) ir = $urandom_range(0, 1) ? 32'h73 : 32'h0010_0073;
      step(r, v, $urandom, ir, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
